stopwatch_datapath: RTL and testbench
=====================================

// Module: stopwatch_datapath
// PURPOSE
//  Time-base and digit counters of the stopwatch, directly downstream of the run/stop/clear FSM.
//  Consumes the FSM's run level, clear pulse and up/down mode select.
//  Produces registered hour:min:sec:centisecond values for the FND display formatter.
//  Contains a clock prescaler generating a 10 ms tick and a cascaded carry/borrow counter chain.
// PARAMETERS
//  F_COUNT   1_000_000  clk cycles per 10 ms tick (100 MHz clk); simulation uses 10
//  MSEC_MAX  100        centisecond modulus (0..99)
//  SEC_MAX   60         second modulus (0..59)
//  MIN_MAX   60         minute modulus (0..59)
//  HOUR_MAX  24         hour modulus (0..23)
// PORTS
//  clk         in   1  system clock
//  reset       in   1  asynchronous, active-low reset
//  i_run_stop  in   1  level; 1 = counting, 0 = hold
//  i_clear     in   1  single-cycle pulse; zero all counters
//  i_mode      in   1  0 = count up, 1 = count down
//  i_lap       in   1  single-cycle pulse; lap hold toggle (LAP_EN only)
//  o_msec      out  7  centiseconds 0..99
//  o_sec       out  6  seconds 0..59
//  o_min       out  6  minutes 0..59
//  o_hour      out  5  hours 0..23
//  o_tick      out  1  one-cycle 10 ms tick pulse (display blink/debug)
// BEHAVIOUR
//  Reset (reset=0, async): prescaler=0, all digits=0, o_tick=0, lap hold=0; all outputs 0.
//  Prescaler: counts 0..F_COUNT-1 only while i_run_stop=1; holds its value while 0 (no restart on resume).
//  Tick: o_tick registered; high for exactly one cycle following the cycle prescaler==F_COUNT-1 with run=1.
//  Digit update: on the clock edge that ends a tick cycle. From cleared state, first o_msec change is F_COUNT+1 edges after i_run_stop rises.
//  Up (i_mode=0): msec+1. At 99, msec wraps to 0 and carries to sec. Sec 59->0 carries to min. Min 59->0 carries to hour. Hour 23->0; full wrap 23:59:59:99 -> 00:00:00:00.
//  Down (i_mode=1): msec-1. At 0, msec wraps to 99 and borrows from sec, cascading. 00:00:00:00 -> 23:59:59:99. No auto-stop.
//  i_mode is sampled at each tick. A mode change mid-run takes effect on the next tick; digits are not altered.
//  i_clear: synchronous; zeros prescaler, all digits and lap hold on the next edge.
//   Overrides a coincident tick (result is all zero) and is honoured whether running or stopped.
//  Widths: each digit register is exactly its port width. Compares use (MAX-1) constants; no out-of-range values are ever produced.
//  i_run_stop falling in a tick cycle: that tick is still applied; no further ticks are generated.
// CONFIGURATION
//  Macro STOPWATCH_LAP_EN:
//   Defined: an i_lap pulse toggles lap hold. On entering hold, outputs capture current digits and freeze while internal counting continues.
//    On leaving hold, outputs track live digits again. i_clear also releases hold.
//   Undefined: the i_lap port is present but ignored; outputs always equal the live digits and no capture registers exist.
// STRUCTURE
//  Shared package/header stopwatch_pkg: F_COUNT default, MSEC/SEC/MIN/HOUR_MAX, digit widths, MODE_UP=0/MODE_DOWN=1.
//  Sub-module tick_gen_10ms (prescaler + o_tick), instantiated once.
//  Digit chain is a single parameterised-modulus counter style, instantiated per digit or written inline.
// TESTING (F_COUNT=10)
//  1. Reset low mid-count -> all outputs 0 immediately. Release, hold run=1 -> o_msec=1 after 11 edges; o_tick period = 10 clks.
//  2. Preload via run to 00:00:59:99 in up mode, one tick -> 00:01:00:00. Then 23:59:59:99 + tick -> 00:00:00:00.
//  3. i_mode=1 from 00:00:00:00, one tick -> 23:59:59:99. From 00:01:00:00, one tick -> 00:00:59:99.
//  4. Run 5 ticks, drop run for 37 clks, raise run -> next tick after the remaining prescaler count; no digit change while stopped.
//  5. Assert i_clear in the same cycle as o_tick -> all digits 0 next edge, prescaler restarts at 0.
//  6. LAP_EN: at o_msec=20, pulse i_lap. After 30 ticks, outputs still read 20. Pulse i_lap -> outputs read 50. Without macro, i_lap has no effect.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants and digit helpers for the stopwatch datapath.
// Optional lap-hold feature is selected with the STOPWATCH_LAP_EN macro.
package stopwatch_pkg;

    localparam int unsigned F_COUNT_DEFAULT = 1_000_000;

    localparam int unsigned MSEC_MAX = 100;
    localparam int unsigned SEC_MAX  = 60;
    localparam int unsigned MIN_MAX  = 60;
    localparam int unsigned HOUR_MAX = 24;

    localparam int unsigned MSEC_W = 7;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

    // Common width used by the digit helpers; wide enough for any digit.
    localparam int unsigned DIGIT_W = 7;

    localparam logic [DIGIT_W-1:0] MSEC_LAST = DIGIT_W'(MSEC_MAX - 1);
    localparam logic [DIGIT_W-1:0] SEC_LAST  = DIGIT_W'(SEC_MAX - 1);
    localparam logic [DIGIT_W-1:0] MIN_LAST  = DIGIT_W'(MIN_MAX - 1);
    localparam logic [DIGIT_W-1:0] HOUR_LAST = DIGIT_W'(HOUR_MAX - 1);

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    // True when a step in the given direction wraps the digit and must ripple on.
    function automatic logic digit_wraps(input logic [DIGIT_W-1:0] value,
                                         input logic [DIGIT_W-1:0] last,
                                         input logic               mode);
        if (mode == MODE_DOWN) begin
            return value == '0;
        end
        return value == last;
    endfunction

    // One modular step of a digit: up wraps last->0, down wraps 0->last.
    function automatic logic [DIGIT_W-1:0] digit_step(input logic [DIGIT_W-1:0] value,
                                                      input logic [DIGIT_W-1:0] last,
                                                      input logic               mode);
        if (mode == MODE_DOWN) begin
            return (value == '0) ? last : value - DIGIT_W'(1);
        end
        return (value == last) ? '0 : value + DIGIT_W'(1);
    endfunction

endpackage

// File: rtl/tick_gen_10ms.sv
// 10 ms time base: prescaler that only advances while running and a registered
// one-cycle tick issued after the prescaler's last count.
module tick_gen_10ms #(
    parameter int unsigned F_COUNT = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned CntW = (F_COUNT > 1) ? $clog2(F_COUNT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(F_COUNT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tick_q, tick_d;

    // Prescaler next state; holds its count while stopped so resume continues mid-period.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_run) begin
            if (cnt_q == LastCnt) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Prescaler and tick registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign o_tick = tick_q;

endmodule

// File: rtl/stopwatch_datapath.sv
// Stopwatch time base and hour:min:sec:centisecond counter chain.
// Define STOPWATCH_LAP_EN to build the lap-hold capture registers.
module stopwatch_datapath
    import stopwatch_pkg::*;
#(
    parameter int unsigned F_COUNT = F_COUNT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run_stop,
    input  logic              i_clear,
    input  logic              i_mode,
    input  logic              i_lap,
    output logic [MSEC_W-1:0] o_msec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic              o_tick
);

    logic              tick;
    logic              sec_en, min_en, hour_en;
    logic [MSEC_W-1:0] msec_q, msec_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [HOUR_W-1:0] hour_q, hour_d;

    tick_gen_10ms #(
        .F_COUNT (F_COUNT)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .i_run   (i_run_stop),
        .i_clear (i_clear),
        .o_tick  (tick)
    );

    // Carry/borrow ripple: each digit steps when all lower digits wrap on this tick.
    always_comb begin
        sec_en  = tick & digit_wraps(DIGIT_W'(msec_q), MSEC_LAST, i_mode);
        min_en  = sec_en & digit_wraps(DIGIT_W'(sec_q), SEC_LAST, i_mode);
        hour_en = min_en & digit_wraps(DIGIT_W'(min_q), MIN_LAST, i_mode);
    end

    // Digit next state; clear wins over a coincident tick.
    always_comb begin
        msec_d = msec_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (i_clear) begin
            msec_d = '0;
            sec_d  = '0;
            min_d  = '0;
            hour_d = '0;
        end else begin
            if (tick) begin
                msec_d = MSEC_W'(digit_step(DIGIT_W'(msec_q), MSEC_LAST, i_mode));
            end
            if (sec_en) begin
                sec_d = SEC_W'(digit_step(DIGIT_W'(sec_q), SEC_LAST, i_mode));
            end
            if (min_en) begin
                min_d = MIN_W'(digit_step(DIGIT_W'(min_q), MIN_LAST, i_mode));
            end
            if (hour_en) begin
                hour_d = HOUR_W'(digit_step(DIGIT_W'(hour_q), HOUR_LAST, i_mode));
            end
        end
    end

    // Live digit registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            msec_q <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
        end else begin
            msec_q <= msec_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic              hold_q, hold_d;
    logic [MSEC_W-1:0] cap_msec_q, cap_msec_d;
    logic [SEC_W-1:0]  cap_sec_q, cap_sec_d;
    logic [MIN_W-1:0]  cap_min_q, cap_min_d;
    logic [HOUR_W-1:0] cap_hour_q, cap_hour_d;

    // Lap toggle; snapshot the displayed live digits when entering hold.
    always_comb begin
        hold_d     = hold_q;
        cap_msec_d = cap_msec_q;
        cap_sec_d  = cap_sec_q;
        cap_min_d  = cap_min_q;
        cap_hour_d = cap_hour_q;
        if (i_clear) begin
            hold_d = 1'b0;
        end else if (i_lap) begin
            hold_d = ~hold_q;
            if (!hold_q) begin
                cap_msec_d = msec_q;
                cap_sec_d  = sec_q;
                cap_min_d  = min_q;
                cap_hour_d = hour_q;
            end
        end
    end

    // Lap hold and capture registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q     <= 1'b0;
            cap_msec_q <= '0;
            cap_sec_q  <= '0;
            cap_min_q  <= '0;
            cap_hour_q <= '0;
        end else begin
            hold_q     <= hold_d;
            cap_msec_q <= cap_msec_d;
            cap_sec_q  <= cap_sec_d;
            cap_min_q  <= cap_min_d;
            cap_hour_q <= cap_hour_d;
        end
    end

    // Display frozen snapshot while holding, live digits otherwise.
    always_comb begin
        o_msec = hold_q ? cap_msec_q : msec_q;
        o_sec  = hold_q ? cap_sec_q  : sec_q;
        o_min  = hold_q ? cap_min_q  : min_q;
        o_hour = hold_q ? cap_hour_q : hour_q;
    end
`else
    logic unused_lap;
    assign unused_lap = i_lap;

    assign o_msec = msec_q;
    assign o_sec  = sec_q;
    assign o_min  = min_q;
    assign o_hour = hour_q;
`endif

    assign o_tick = tick;

endmodule

// File: tb/tb_stopwatch_datapath.sv
// Self-checking bench for stopwatch_datapath with F_COUNT=10: directed vector
// table, hand-written wrap/clear/lap sequences, then random stimulus against a
// model that keeps time as a single centisecond count modulo one day.
module tb_stopwatch_datapath;

    localparam int F   = 10;
    localparam int DAY = 100 * 60 * 60 * 24;

    logic       clk = 1'b0;
    logic       reset, run, clr, mode, lap;
    logic [6:0] msec;
    logic [5:0] sec, min;
    logic [4:0] hour;
    logic       tick;

    int errors = 0;
    int checks = 0;

    // Model state: time in centiseconds, prescaler count, pending tick, lap hold.
    int m_t, m_pre, m_cap;
    bit m_tick, m_hold;

    stopwatch_datapath #(
        .F_COUNT (F)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_run_stop (run),
        .i_clear    (clr),
        .i_mode     (mode),
        .i_lap      (lap),
        .o_msec     (msec),
        .o_sec      (sec),
        .o_min      (min),
        .o_hour     (hour),
        .o_tick     (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit    run;
        bit    mode;
        bit    clr;
        int    n;
        int    cs;
        bit    tk;
    } vec_t;

    vec_t vecs[$];

    task automatic model_reset();
        m_t = 0; m_pre = 0; m_tick = 0; m_hold = 0; m_cap = 0;
    endtask

    task automatic model_edge();
        bit fire;
        int t_old;
        if (clr) begin
            model_reset();
        end else begin
            t_old = m_t;
            fire  = run && (m_pre == F - 1);
            if (m_tick) m_t = mode ? (m_t + DAY - 1) % DAY : (m_t + 1) % DAY;
`ifdef STOPWATCH_LAP_EN
            if (lap) begin
                if (!m_hold) m_cap = t_old;
                m_hold = !m_hold;
            end
`endif
            if (run) m_pre = fire ? 0 : m_pre + 1;
            m_tick = fire;
        end
    endtask

    task automatic check_vals(input string name, input int h, input int mi, input int s,
                              input int cs, input bit tk);
        checks++;
        if (hour !== h[4:0] || min !== mi[5:0] || sec !== s[5:0] || msec !== cs[6:0] ||
            tick !== tk) begin
            errors++;
            $display("FAIL %s: got %0d:%0d:%0d.%0d tick=%0d, expected %0d:%0d:%0d.%0d tick=%0d",
                     name, hour, min, sec, msec, tick, h, mi, s, cs, tk);
        end
    endtask

    task automatic check_model(input string name);
        int shown;
        shown = m_hold ? m_cap : m_t;
        check_vals(name, shown / 360000, (shown / 6000) % 60, (shown / 100) % 60, shown % 100,
                   m_tick);
    endtask

    // One clock: DUT and model both take the edge; return at the following negedge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; clr = 1'b0; mode = 1'b0; lap = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_vals("reset_state", 0, 0, 0, 0, 0);
        reset = 1'b1;

        // Asynchronous reset in the middle of counting.
        run = 1'b1;
        step(25);
        check_vals("pre_async_reset", 0, 0, 0, 2, 0);
        #2 reset = 1'b0;
        model_reset();
        #1 check_vals("async_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // Directed table from the cleared state.
        vecs.push_back('{"first_tick",    1, 0, 0, 10, 0, 1});
        vecs.push_back('{"first_update",  1, 0, 0,  1, 1, 0});
        vecs.push_back('{"tick_period",   1, 0, 0,  9, 1, 1});
        vecs.push_back('{"second_update", 1, 0, 0,  1, 2, 0});
        vecs.push_back('{"partial_count", 1, 0, 0,  3, 2, 0});
        vecs.push_back('{"stopped_hold",  0, 0, 0, 37, 2, 0});
        vecs.push_back('{"resume_early",  1, 0, 0,  5, 2, 0});
        vecs.push_back('{"resume_tick",   1, 0, 0,  1, 2, 1});
        vecs.push_back('{"resume_update", 1, 0, 0,  1, 3, 0});
        vecs.push_back('{"tick_then_stop",1, 0, 0,  9, 3, 1});
        vecs.push_back('{"stop_in_tick",  0, 0, 0,  1, 4, 0});
        vecs.push_back('{"stop_no_ticks", 0, 0, 0, 20, 4, 0});
        vecs.push_back('{"down_tick",     1, 1, 0, 10, 4, 1});
        vecs.push_back('{"down_update",   1, 1, 0,  1, 3, 0});
        vecs.push_back('{"clear_stopped", 0, 0, 1,  1, 0, 0});
        foreach (vecs[k]) begin
            run = vecs[k].run; mode = vecs[k].mode; clr = vecs[k].clr;
            step(vecs[k].n);
            check_vals(vecs[k].name, 0, 0, 0, vecs[k].cs, vecs[k].tk);
            check_model({vecs[k].name, "_model"});
        end
        clr = 1'b0;

        // Clear coincident with a tick, then the prescaler restarts from zero.
        run = 1'b1; mode = 1'b0;
        step(10);
        check_vals("tick_before_clear", 0, 0, 0, 0, 1);
        pulse_clear();
        check_vals("clear_over_tick", 0, 0, 0, 0, 0);
        step(9);
        check_vals("restart_no_tick", 0, 0, 0, 0, 0);
        step(1);
        check_vals("restart_tick", 0, 0, 0, 0, 1);
        step(1);
        check_vals("restart_update", 0, 0, 0, 1, 0);

        // Full borrow and full carry across the day boundary.
        pulse_clear();
        mode = 1'b1;
        step(11);
        check_vals("down_day_wrap", 23, 59, 59, 99, 0);
        mode = 1'b0;
        step(10);
        check_vals("up_day_wrap", 0, 0, 0, 0, 0);

        // Second carry, then borrow back.
        pulse_clear();
        step(1001);
        check_vals("sec_carry", 0, 0, 1, 0, 0);
        mode = 1'b1;
        step(10);
        check_vals("sec_borrow", 0, 0, 0, 99, 0);
        check_model("sec_borrow_model");

        // Lap hold.
        pulse_clear();
        mode = 1'b0;
        step(201);
        check_vals("lap_start", 0, 0, 0, 20, 0);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        step(300);
`ifdef STOPWATCH_LAP_EN
        check_vals("lap_frozen", 0, 0, 0, 20, 0);
`else
        check_vals("lap_ignored", 0, 0, 0, 50, 0);
`endif
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        check_vals("lap_release", 0, 0, 0, 50, 0);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            run = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) mode = ~mode;
            lap = ($urandom_range(0, 49) == 0);
            // Skip a clear landing on a tick-generating cycle; that corner is directed above.
            clr = ($urandom_range(0, 299) == 0) && !(run && m_pre == F - 1);
            step(1);
            check_model("random");
        end
        run = 1'b0; clr = 1'b0; lap = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
